// File: rtl/cp0_irq_ctrl_pkg.sv
// Shared constants for the CP0 exception/interrupt controller: register numbers,
// SR/Cause bit positions, ExcCode values and the default handler entry address.
package cp0_irq_ctrl_pkg;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;

    localparam int SR_IE     = 0;
    localparam int SR_EXL    = 1;
    localparam int IP_LSB    = 10;
    localparam int EXC_LSB   = 2;
    localparam int CAUSE_TI  = 30;
    localparam int CAUSE_BD  = 31;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    localparam logic [31:0] DEFAULT_HANDLER_PC = 32'h0000_4180;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/cp0_irq_ctrl_if.sv
// mtc0/mfc0 register-access bus between the M stage and CP0.
// The M stage owns we/addr/wdata; CP0 answers with combinational rdata.
interface cp0_irq_ctrl_if;
    logic        we_i;
    logic [4:0]  addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;

    modport master (output we_i, addr_i, wdata_i, input rdata_o);
    modport slave  (input we_i, addr_i, wdata_i, output rdata_o);
endinterface

// File: rtl/cp0_irq_sync.sv
// Interrupt capture: registers irq lines; level channels follow the register,
// edge channels latch a sticky pending bit that software clears via Cause.
module cp0_irq_sync #(
    parameter int         NUM_IRQ   = 6,
    parameter logic [5:0] EDGE_MASK = 6'b000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               clr_en_i,
    input  logic [NUM_IRQ-1:0] clr_keep_i,
    output logic [NUM_IRQ-1:0] ip_o
);

    localparam logic [NUM_IRQ-1:0] EDGE = EDGE_MASK[NUM_IRQ-1:0];

    logic [NUM_IRQ-1:0] irq_q, irq_d;
    logic [NUM_IRQ-1:0] edge_ip_q, edge_ip_d;

    always_comb begin
        irq_d     = irq_i;
        edge_ip_d = edge_ip_q;
        if (clr_en_i) begin
            edge_ip_d = edge_ip_q & clr_keep_i;
        end
        // A new rising edge wins over a same-cycle software clear.
        edge_ip_d = (edge_ip_d | (irq_i & ~irq_q)) & EDGE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q     <= '0;
            edge_ip_q <= '0;
        end else begin
            irq_q     <= irq_d;
            edge_ip_q <= edge_ip_d;
        end
    end

    assign ip_o = (irq_q & ~EDGE) | (edge_ip_q & EDGE);

endmodule

// File: rtl/cp0_irq_ctrl.sv
// CP0 exception/interrupt controller beside the M stage: SR/Cause/EPC/PRId,
// one-cycle take decision and victim-PC capture. Optional Count/Compare: CP0_COUNT_EN.
module cp0_irq_ctrl
    import cp0_irq_ctrl_pkg::*;
#(
    parameter int          NUM_IRQ       = 6,
    parameter logic [5:0]  IRQ_EDGE_MASK = 6'b000000,
    parameter logic [31:0] HANDLER_PC    = DEFAULT_HANDLER_PC,
    parameter logic [31:0] PRID          = 32'h0000_0007
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               exc_valid_i,
    input  logic [4:0]         exc_code_i,
    input  logic               bd_i,
    input  logic [31:0]        pc_m_i,
    input  logic [31:0]        pc_e_i,
    input  logic [31:0]        pc_d_i,
    input  logic [31:0]        pc_f_i,
    input  logic               vld_m_i,
    input  logic               vld_e_i,
    input  logic               vld_d_i,
    cp0_irq_ctrl_if.slave      bus,
    input  logic               eret_i,
    output logic               take_o,
    output logic [31:0]        handler_pc_o,
    output logic [31:0]        epc_o
);

    logic [NUM_IRQ-1:0] im_q, im_d;
    logic               exl_q, exl_d;
    logic               ie_q, ie_d;
    logic               bd_q, bd_d;
    logic [4:0]         exc_code_q, exc_code_d;
    logic [31:0]        epc_q, epc_d;

    logic [NUM_IRQ-1:0] ip_raw, ip_eff;
    logic               ti;
    logic               int_req, exc_req, take;
    logic               wr_en, bd_eff;
    logic [31:0]        victim;

    cp0_irq_sync #(
        .NUM_IRQ   (NUM_IRQ),
        .EDGE_MASK (IRQ_EDGE_MASK)
    ) u_sync (
        .clk        (clk),
        .reset      (reset),
        .irq_i      (irq_i),
        .clr_en_i   (wr_en && (bus.addr_i == REG_CAUSE)),
        .clr_keep_i (bus.wdata_i[IP_LSB +: NUM_IRQ]),
        .ip_o       (ip_raw)
    );

`ifdef CP0_COUNT_EN
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;

    always_comb begin
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        ti_d      = ti_q | (count_q == compare_q);
        if (wr_en && (bus.addr_i == REG_COUNT)) begin
            count_d = bus.wdata_i;
        end
        if (wr_en && (bus.addr_i == REG_COMPARE)) begin
            compare_d = bus.wdata_i;
            ti_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign ti = ti_q;
    // Timer interrupt shares the top interrupt channel as a level source.
    always_comb begin
        ip_eff = ip_raw;
        ip_eff[NUM_IRQ-1] = ip_raw[NUM_IRQ-1] | ti_q;
    end
`else
    assign ti     = 1'b0;
    assign ip_eff = ip_raw;
`endif

    assign int_req = (|(ip_eff & im_q)) & ie_q & ~exl_q;
    assign exc_req = exc_valid_i & ~exl_q;
    assign take    = int_req | exc_req;
    assign wr_en   = bus.we_i & ~take;
    assign bd_eff  = bd_i & vld_m_i;

    always_comb begin
        if (vld_m_i)      victim = pc_m_i;
        else if (vld_e_i) victim = pc_e_i;
        else if (vld_d_i) victim = pc_d_i;
        else              victim = pc_f_i;
    end

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        if (wr_en) begin
            case (bus.addr_i)
                REG_SR: begin
                    im_d  = bus.wdata_i[IP_LSB +: NUM_IRQ];
                    exl_d = bus.wdata_i[SR_EXL];
                    ie_d  = bus.wdata_i[SR_IE];
                end
                REG_EPC: epc_d = word_align(bus.wdata_i);
                default: ;
            endcase
        end
        if (eret_i) begin
            exl_d = 1'b0;
        end
        if (take) begin
            exl_d      = 1'b1;
            bd_d       = bd_eff;
            epc_d      = word_align(bd_eff ? (victim - 32'd4) : victim);
            exc_code_d = int_req ? 5'(EXC_INT) : exc_code_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            exc_code_q <= '0;
            epc_q      <= '0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

    // Reads reflect registered state, so a same-cycle mtc0 returns the old value.
    always_comb begin
        bus.rdata_o = '0;
        case (bus.addr_i)
            REG_SR: begin
                bus.rdata_o[IP_LSB +: NUM_IRQ] = im_q;
                bus.rdata_o[SR_EXL]            = exl_q;
                bus.rdata_o[SR_IE]             = ie_q;
            end
            REG_CAUSE: begin
                bus.rdata_o[CAUSE_BD]              = bd_q;
                bus.rdata_o[CAUSE_TI]              = ti;
                bus.rdata_o[IP_LSB +: NUM_IRQ]     = ip_eff;
                bus.rdata_o[EXC_LSB +: 5]          = exc_code_q;
            end
            REG_EPC:  bus.rdata_o = epc_q;
            REG_PRID: bus.rdata_o = PRID;
`ifdef CP0_COUNT_EN
            REG_COUNT:   bus.rdata_o = count_q;
            REG_COMPARE: bus.rdata_o = compare_q;
`endif
            default: bus.rdata_o = '0;
        endcase
    end

    assign take_o       = take;
    assign handler_pc_o = HANDLER_PC;
    assign epc_o        = epc_q;

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Directed bench for cp0_irq_ctrl with channel 1 configured as edge-latched.
module tb_cp0_irq_ctrl;
  import cp0_irq_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  irq_i;
  logic        exc_valid_i;
  logic [4:0]  exc_code_i;
  logic        bd_i;
  logic [31:0] pc_m_i, pc_e_i, pc_d_i, pc_f_i;
  logic        vld_m_i, vld_e_i, vld_d_i;
  logic        eret_i;
  logic        take_o;
  logic [31:0] handler_pc_o;
  logic [31:0] epc_o;
  logic [31:0] rd;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  cp0_irq_ctrl_if bus();

  cp0_irq_ctrl #(
    .NUM_IRQ       (6),
    .IRQ_EDGE_MASK (6'b000010),
    .HANDLER_PC    (32'h0000_4180),
    .PRID          (32'h0000_0007)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .irq_i        (irq_i),
    .exc_valid_i  (exc_valid_i),
    .exc_code_i   (exc_code_i),
    .bd_i         (bd_i),
    .pc_m_i       (pc_m_i),
    .pc_e_i       (pc_e_i),
    .pc_d_i       (pc_d_i),
    .pc_f_i       (pc_f_i),
    .vld_m_i      (vld_m_i),
    .vld_e_i      (vld_e_i),
    .vld_d_i      (vld_d_i),
    .bus          (bus),
    .eret_i       (eret_i),
    .take_o       (take_o),
    .handler_pc_o (handler_pc_o),
    .epc_o        (epc_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_reg(input logic [4:0] a, output logic [31:0] d);
    bus.addr_i = a;
    #1;
    d = bus.rdata_o;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.we_i    = 1'b1;
    bus.addr_i  = a;
    bus.wdata_i = d;
    tick();
    bus.we_i    = 1'b0;
  endtask

  task automatic check_epc(input string tag);
    logic [31:0] e;
    e = exp_q.pop_front();
    check(tag, epc_o, e);
  endtask

  initial begin
    reset = 1'b1;
    irq_i = '0; exc_valid_i = 1'b0; exc_code_i = '0; bd_i = 1'b0;
    pc_m_i = '0; pc_e_i = '0; pc_d_i = '0; pc_f_i = '0;
    vld_m_i = 1'b0; vld_e_i = 1'b0; vld_d_i = 1'b0; eret_i = 1'b0;
    bus.we_i = 1'b0; bus.addr_i = '0; bus.wdata_i = '0;
    tick(); tick();
    reset = 1'b0;

    // reset state
    check("rst_take", {31'd0, take_o}, 32'd0);
    check("rst_epc", epc_o, 32'd0);
    rd_reg(5'd0, rd);      check("rst_rd0", rd, 32'd0);
    rd_reg(REG_SR, rd);    check("rst_sr", rd, 32'd0);
    rd_reg(REG_CAUSE, rd); check("rst_cause", rd, 32'd0);
    rd_reg(REG_PRID, rd);  check("prid", rd, 32'h7);
    check("handler_pc", handler_pc_o, 32'h0000_4180);
    tick();

    // level interrupt on channel 2 from M
    mtc0(REG_SR, 32'h0000_FC01);
    rd_reg(REG_SR, rd); check("sr_wr", rd, 32'h0000_FC01);
    irq_i = 6'b000100; vld_m_i = 1'b1; pc_m_i = 32'h3010;
    #1 check("irq_reg_lat", {31'd0, take_o}, 32'd0);
    exp_q.push_back(32'h3010);
    tick();
    check("int_take", {31'd0, take_o}, 32'd1);
    tick();
    check_epc("int_epc");
    rd_reg(REG_CAUSE, rd); check("int_cause", rd, 32'h0000_1000);
    rd_reg(REG_SR, rd);    check("int_exl", rd, 32'h0000_FC03);
    check("exl_block", {31'd0, take_o}, 32'd0);
    irq_i = '0;

    // synchronous exception in a delay slot
    mtc0(REG_SR, 32'h0000_FC01);
    exc_valid_i = 1'b1; exc_code_i = 5'd12; bd_i = 1'b1; pc_m_i = 32'h3020;
    exp_q.push_back(32'h301C);
    #1 check("exc_take", {31'd0, take_o}, 32'd1);
    tick();
    exc_valid_i = 1'b0; bd_i = 1'b0;
    check_epc("exc_bd_epc");
    rd_reg(REG_CAUSE, rd); check("exc_cause", rd, 32'h8000_0030);
    exc_valid_i = 1'b1; exc_code_i = 5'd4; pc_m_i = 32'h3030;
    #1 check("exc_nested", {31'd0, take_o}, 32'd0);
    tick();
    exc_valid_i = 1'b0;
    check("exc_epc_hold", epc_o, 32'h301C);

    // all stages are bubbles -> fetch PC becomes victim
    mtc0(REG_SR, 32'h0000_FC01);
    vld_m_i = 1'b0; pc_m_i = 32'h5555; pc_f_i = 32'h3040; irq_i = 6'b000001;
    exp_q.push_back(32'h3040);
    tick();
    check("bubble_take", {31'd0, take_o}, 32'd1);
    tick();
    irq_i = '0;
    check_epc("bubble_epc");
    rd_reg(REG_CAUSE, rd); check("bubble_cause", rd, 32'h0000_0400);

    // edge channel 1: sticky pending and software clear
    mtc0(REG_SR, 32'h0);
    irq_i = 6'b000010;
    tick();
    irq_i = '0;
    rd_reg(REG_CAUSE, rd); check("edge_set", rd, 32'h0000_0800);
    tick();
    rd_reg(REG_CAUSE, rd); check("edge_sticky", rd, 32'h0000_0800);
    mtc0(REG_CAUSE, 32'h0);
    rd_reg(REG_CAUSE, rd); check("edge_clr", rd, 32'h0);
    irq_i = 6'b000010;
    bus.we_i = 1'b1; bus.addr_i = REG_CAUSE; bus.wdata_i = 32'h0;
    tick();
    bus.we_i = 1'b0; irq_i = '0;
    rd_reg(REG_CAUSE, rd); check("edge_set_wins", rd, 32'h0000_0800);
    mtc0(REG_CAUSE, 32'h0);

    // eret with interrupt still pending
    irq_i = 6'b000100; vld_m_i = 1'b1; pc_m_i = 32'h3100;
    exp_q.push_back(32'h3100);
    mtc0(REG_SR, 32'h0000_FC01);
    check("pre_eret_take", {31'd0, take_o}, 32'd1);
    tick();
    check_epc("pre_eret_epc");
    pc_m_i = 32'h3200; eret_i = 1'b1;
    #1 check("eret_no_take", {31'd0, take_o}, 32'd0);
    check("eret_epc_stable", epc_o, 32'h3100);
    exp_q.push_back(32'h3200);
    tick();
    eret_i = 1'b0;
    check("post_eret_take", {31'd0, take_o}, 32'd1);
    tick();
    irq_i = '0;
    check_epc("post_eret_epc");

    // EPC write, read-during-write, read-only PRId, unimplemented register
    bus.we_i = 1'b1; bus.addr_i = REG_EPC; bus.wdata_i = 32'h1234_5677;
    #1 check("rdw_old", bus.rdata_o, 32'h3200);
    tick();
    bus.we_i = 1'b0;
    rd_reg(REG_EPC, rd); check("epc_wr_align", rd, 32'h1234_5674);
    mtc0(REG_PRID, 32'hFFFF_FFFF);
    rd_reg(REG_PRID, rd); check("prid_ro", rd, 32'h7);
    rd_reg(5'd3, rd); check("unimpl_rd", rd, 32'h0);

    // take wins over a same-cycle mtc0
    mtc0(REG_SR, 32'h0);
    exc_valid_i = 1'b1; exc_code_i = 5'd4; vld_m_i = 1'b1; pc_m_i = 32'h3300;
    bus.we_i = 1'b1; bus.addr_i = REG_EPC; bus.wdata_i = 32'hDEAD_0000;
    exp_q.push_back(32'h3300);
    tick();
    exc_valid_i = 1'b0; bus.we_i = 1'b0;
    check_epc("take_beats_mtc0");
    rd_reg(REG_CAUSE, rd); check("adel_cause", rd, 32'h0000_0010);

    // asynchronous reset mid-cycle
    #2 reset = 1'b1;
    #1 check("areset_epc", epc_o, 32'h0);
    rd_reg(REG_SR, rd);    check("areset_sr", rd, 32'h0);
    rd_reg(REG_CAUSE, rd); check("areset_cause", rd, 32'h0);
    tick();
    reset = 1'b0;
    tick();

`ifdef CP0_COUNT_EN
    begin
      bit got_take = 1'b0;
      mtc0(REG_COMPARE, 32'd20);
      mtc0(REG_COUNT, 32'd0);
      mtc0(REG_SR, 32'h0000_FC01);
      for (int i = 0; i < 40 && !got_take; i++) begin
        if (take_o) got_take = 1'b1;
        else tick();
      end
      check("ti_take", {31'd0, got_take}, 32'd1);
      tick();
      rd_reg(REG_CAUSE, rd); check("ti_set", rd & 32'h4000_0000, 32'h4000_0000);
      mtc0(REG_COMPARE, 32'd1000);
      rd_reg(REG_CAUSE, rd); check("ti_clr", rd & 32'h4000_0000, 32'h0);
    end
`endif

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
